// File: rtl/cosine_lut_arbiter.sv
// Round-robin sharing of one cosine LUT read port between NUM_REQ requesters.
// Two-stage pipeline: registered LUT address, then registered sample and one-hot tag.
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 48
`endif
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif

module cosine_lut_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SAMPLES = `CARRIER_SAMPLES_PER_PERIOD,
  parameter int IDX_W   = $clog2(`CARRIER_SAMPLES_PER_PERIOD),
  parameter int DATA_W  = `FIXDT_64_A_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         lut_idx,
  input  logic [DATA_W-1:0]        lut_data,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     wrap_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_id;
  logic             grant_any;
  logic [PTR_W-1:0] s1_owner;
  logic             s1_valid;
  logic [IDX_W-1:0] idx_sel;
  logic [IDX_W-1:0] idx_mod;
  logic             idx_wrap;
  logic [NUM_REQ-1:0] owner_oh;

  // Descending scan so the candidate closest to ptr is the last one written.
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    if (rst_n && en) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        j = (int'(ptr) + k) % NUM_REQ;
        if (req_valid[j]) begin
          grant_any = 1'b1;
          grant_id  = PTR_W'(j);
        end
      end
    end
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    idx_sel  = req_idx[int'(grant_id)*IDX_W +: IDX_W];
    idx_wrap = int'(idx_sel) >= SAMPLES;
    idx_mod  = idx_wrap ? idx_sel - IDX_W'(SAMPLES) : idx_sel;
    owner_oh = '0;
    owner_oh[s1_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s1_owner  <= '0;
      lut_idx   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      wrap_err  <= 1'b0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_owner <= grant_id;
        lut_idx  <= idx_mod;
        ptr      <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
        if (idx_wrap) wrap_err <= 1'b1;
      end
      rsp_valid <= s1_valid ? owner_oh : '0;
      if (s1_valid) rsp_data <= lut_data;
    end
  end

endmodule
